// File: rtl/rx_buffer_pkg.sv
// Shared UART codec definitions: frame geometry, timeout default and FSM state encoding.
// Also used by the transmit-side serializer, so frame geometry must stay in sync with it.
package rx_buffer_pkg;

  localparam int unsigned BYTES_DEFAULT          = 16;
  localparam int unsigned DATA_W_DEFAULT         = 8 * BYTES_DEFAULT;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 50000;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StCollect = COLLECT,
    StFull    = FULL
  } state_e;

endpackage

// File: rtl/rx_buffer_if.sv
// Character-in / word-out bundle of the receive frame assembler.
interface rx_buffer_if #(
  parameter int unsigned BYTES = rx_buffer_pkg::BYTES_DEFAULT
);
  localparam int unsigned DATA_W = 8 * BYTES;

  logic              rx_done;
  logic [7:0]        data_rx;
  logic              in_ready;
  logic              ovf_clr;
  logic              in_en;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              overflow;
  logic              timeout;

  modport master (
    output rx_done, data_rx, in_ready, ovf_clr,
    input  in_en, in_data, busy, overflow, timeout
  );

  modport slave (
    input  rx_done, data_rx, in_ready, ovf_clr,
    output in_en, in_data, busy, overflow, timeout
  );

endinterface

// File: rtl/rx_gap_timer.sv
// Inter-character gap counter: pulses expire once the gap reaches CYCLES-1 while active.
module rx_gap_timer #(
  parameter int unsigned CYCLES = rx_buffer_pkg::TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic active,
  input  logic restart,
  output logic expire
);
  localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (restart || !active) begin
      cnt_q <= '0;
    end else if (!expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = active && (cnt_q == CntW'(CYCLES - 1));

endmodule

// File: rtl/rx_buffer.sv
// Receive frame assembler: packs BYTES characters (first one in the MSBs) into one word.
// Optional inter-byte timeout under macro RX_TIMEOUT_EN.
module rx_buffer
  import rx_buffer_pkg::*;
#(
  parameter int unsigned BYTES          = BYTES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic        clk,
  input logic        rstn,
  rx_buffer_if.slave bus
);
  localparam int unsigned DATA_W = 8 * BYTES;
  localparam int unsigned CW     = $clog2(BYTES);

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] in_data_q;
  logic              in_en_q;
  logic              overflow_q;
  logic              timeout_q;
  logic [DATA_W-1:0] shift_next;
  logic              expire;
  logic              gap_hit;

  assign shift_next = {shreg_q[DATA_W-9:0], bus.data_rx};

`ifdef RX_TIMEOUT_EN
  rx_gap_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rstn    (rstn),
    .active  (state_q == StCollect),
    .restart (bus.rx_done),
    .expire  (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // A character arriving in the expiry cycle keeps the frame alive.
  assign gap_hit = expire && !bus.rx_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      count_q    <= '0;
      shreg_q    <= '0;
      in_data_q  <= '0;
      in_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (bus.ovf_clr) overflow_q <= 1'b0;
      unique case (state_q)
        StIdle, StCollect: begin
          if (bus.rx_done) begin
            shreg_q <= shift_next;
            if (count_q == CW'(BYTES - 1)) begin
              in_data_q <= shift_next;
              in_en_q   <= 1'b1;
              count_q   <= '0;
              state_q   <= StFull;
            end else begin
              count_q <= count_q + 1'b1;
              state_q <= StCollect;
            end
          end else if (gap_hit) begin
            count_q   <= '0;
            shreg_q   <= '0;
            state_q   <= StIdle;
            timeout_q <= 1'b1;
          end
        end
        StFull: begin
          if (bus.in_ready) begin
            in_en_q <= 1'b0;
            if (bus.rx_done) begin
              // Accepted word and first byte of the next frame share this edge.
              shreg_q <= {{(DATA_W-8){1'b0}}, bus.data_rx};
              count_q <= CW'(1);
              state_q <= StCollect;
            end else begin
              state_q <= StIdle;
            end
          end else if (bus.rx_done) begin
            overflow_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_en    = in_en_q;
  assign bus.in_data  = in_data_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.overflow = overflow_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rx_buffer.sv
// Directed bench for rx_buffer; timeout scenarios run when RX_TIMEOUT_EN is defined.
module tb_rx_buffer;

  localparam int unsigned BYTES  = 16;
  localparam int unsigned DATA_W = 8 * BYTES;

  logic clk = 1'b0;
  logic rstn;
  int   vectors     = 0;
  int   miscompares = 0;

  rx_buffer_if #(.BYTES(BYTES)) bus ();

  rx_buffer #(
    .BYTES          (BYTES),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    bus.data_rx = d;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_to;
    int to_pos;
    rstn         = 1'b0;
    bus.rx_done  = 1'b0;
    bus.data_rx  = 8'h00;
    bus.in_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    tick();
    tick();
    check("rst_in_en", DATA_W'(bus.in_en), '0);
    check("rst_in_data", bus.in_data, '0);
    check("rst_busy", DATA_W'(bus.busy), '0);
    check("rst_overflow", DATA_W'(bus.overflow), '0);
    check("rst_timeout", DATA_W'(bus.timeout), '0);
    rstn = 1'b1;
    tick();

    // Spaced frame 0x00..0x0F with consumer always ready.
    bus.in_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (i == 14) check("t1_no_early_en", DATA_W'(bus.in_en), '0);
      if (i < 15) begin
        tick();
        tick();
        tick();
      end
    end
    check("t1_in_en", DATA_W'(bus.in_en), 1);
    check("t1_in_data", bus.in_data, 128'h000102030405060708090A0B0C0D0E0F);
    tick();
    check("t1_in_en_fall", DATA_W'(bus.in_en), '0);
    check("t1_busy_low", DATA_W'(bus.busy), '0);
    check("t1_data_held", bus.in_data, 128'h000102030405060708090A0B0C0D0E0F);

    // Backpressure and overflow.
    bus.in_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i));
    check("t2_in_en", DATA_W'(bus.in_en), 1);
    check("t2_in_data", bus.in_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    check("t2_no_ovf_yet", DATA_W'(bus.overflow), '0);
    send(8'h55);
    check("t2_in_en_held", DATA_W'(bus.in_en), 1);
    check("t2_data_held", bus.in_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    check("t2_overflow", DATA_W'(bus.overflow), 1);
    check("t2_busy_full", DATA_W'(bus.busy), 1);
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    check("t2_in_en_fall", DATA_W'(bus.in_en), '0);
    check("t2_ovf_sticky", DATA_W'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t2_ovf_clr", DATA_W'(bus.overflow), '0);

    // Accept and next first byte on the same edge.
    for (int i = 0; i < 16; i++) send(8'hB0 + 8'(i));
    check("t3_full", DATA_W'(bus.in_en), 1);
    bus.in_ready = 1'b1;
    send(8'h11);
    bus.in_ready = 1'b0;
    check("t3_accepted", DATA_W'(bus.in_en), '0);
    check("t3_no_ovf", DATA_W'(bus.overflow), '0);
    check("t3_busy", DATA_W'(bus.busy), 1);
    for (int i = 0; i < 15; i++) send(8'h12 + 8'(i));
    check("t3_in_en", DATA_W'(bus.in_en), 1);
    check("t3_in_data", bus.in_data, 128'h1112131415161718191A1B1C1D1E1F20);
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    check("t3_drain", DATA_W'(bus.in_en), '0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) send(8'hFF);
    check("t4_busy_pre", DATA_W'(bus.busy), 1);
    rstn = 1'b0;
    tick();
    tick();
    check("t4_rst_in_en", DATA_W'(bus.in_en), '0);
    check("t4_rst_in_data", bus.in_data, '0);
    check("t4_rst_busy", DATA_W'(bus.busy), '0);
    check("t4_rst_ovf", DATA_W'(bus.overflow), '0);
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) send(8'h01);
    check("t4_in_en", DATA_W'(bus.in_en), 1);
    check("t4_in_data", bus.in_data, 128'h01010101010101010101010101010101);
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;

`ifdef RX_TIMEOUT_EN
    // Partial frame followed by a 20-cycle gap.
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i));
    n_to   = 0;
    to_pos = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.timeout) begin
        n_to++;
        to_pos = i;
      end
    end
    check("t5_timeout_cnt", DATA_W'(n_to), 1);
    check("t5_timeout_pos", DATA_W'(to_pos), 19);
    check("t5_busy", DATA_W'(bus.busy), '0);
    tick();
    check("t5_pulse_end", DATA_W'(bus.timeout), '0);
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
    check("t5_in_data", bus.in_data, 128'h303132333435363738393A3B3C3D3E3F);
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;

    // 19 idle cycles between bytes stays inside the limit.
    n_to = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'h40 + 8'(i));
      if (bus.timeout) n_to++;
      if (i < 15) begin
        for (int j = 0; j < 19; j++) begin
          tick();
          if (bus.timeout) n_to++;
        end
      end
    end
    check("t6_no_timeout", DATA_W'(n_to), '0);
    check("t6_in_en", DATA_W'(bus.in_en), 1);
    check("t6_in_data", bus.in_data, 128'h404142434445464748494A4B4C4D4E4F);
`else
    // Without the timer a partial frame just waits.
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i));
    n_to   = 0;
    to_pos = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.timeout) n_to++;
    end
    check("t5_no_timeout", DATA_W'(n_to), DATA_W'(to_pos));
    check("t5_still_busy", DATA_W'(bus.busy), 1);
    for (int i = 3; i < 16; i++) send(8'hC0 + 8'(i));
    check("t5_in_en", DATA_W'(bus.in_en), 1);
    check("t5_in_data", bus.in_data, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
